// File: rtl/bus_addr_dec_prog_if.sv
// -----------------------------------------------------------------------------
// bus_addr_dec_prog_if
// Bus-side signal bundle for the programmable address decoder.
//   s_addr   : word address from the arbiter
//   s_as_    : address strobe, active-low
//   s_rdy_   : ready from the selected slave, active-low
//   s_cs_    : chip selects, active-low, at most one low
//   s_idx    : index of the selected slave
//   busy     : transaction in progress
//   err_rdy_ : one-cycle error ready to the master, active-low
//   err_code : 00 none, 01 decode miss, 10 timeout
// The "slave" modport is the decoder's view; "master" is the bus-side view.
// -----------------------------------------------------------------------------
interface bus_addr_dec_prog_if #(
   parameter int ADDR_W   = 30,
   parameter int N_SLAVES = 8,
   parameter int IDX_W    = $clog2(N_SLAVES)
);
   logic [ADDR_W-1:0]   s_addr;
   logic                s_as_;
   logic                s_rdy_;
   logic [N_SLAVES-1:0] s_cs_;
   logic [IDX_W-1:0]    s_idx;
   logic                busy;
   logic                err_rdy_;
   logic [1:0]          err_code;

   modport slave (
      input  s_addr, s_as_, s_rdy_,
      output s_cs_, s_idx, busy, err_rdy_, err_code
   );

   modport master (
      output s_addr, s_as_, s_rdy_,
      input  s_cs_, s_idx, busy, err_rdy_, err_code
   );
endinterface

// File: rtl/bus_addr_dec_prog.sv
// -----------------------------------------------------------------------------
// bus_addr_dec_prog
// Programmable address decoder with registered per-transaction chip select.
// Each region has a runtime base/mask/enable entry; the selection is latched
// on address strobe and held until the slave answers ready. Unmatched
// addresses and slaves that never answer get an error ready instead.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : decoder-side bus bundle (see bus_addr_dec_prog_if)
//   cfg_we     : config write enable
//   cfg_idx    : entry to write (out-of-range indices are ignored)
//   cfg_sel    : 00 base, 01 mask, 10 enable (bit 0), 11 ignored
//   cfg_wdata  : config data
// -----------------------------------------------------------------------------
module bus_addr_dec_prog #(
   parameter int ADDR_W   = 30,
   parameter int N_SLAVES = 8,
   parameter int IDX_W    = $clog2(N_SLAVES),
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   bus_addr_dec_prog_if.slave bus,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [1:0]        cfg_sel,
   input  logic [ADDR_W-1:0] cfg_wdata
);
   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

   state_t              state_q;
   logic [N_SLAVES-1:0] cs_q;
   logic [IDX_W-1:0]    idx_q;
   logic                busy_q;
   logic                err_rdy_q;
   logic [1:0]          err_code_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;

   logic [N_SLAVES-1:0] hit;
   logic                hit_any;
   logic [IDX_W-1:0]    hit_idx;

   // Region table: one base/mask/enable triple per entry. Reset values give
   // plain top-bits decoding (entry i owns the i-th slice of the address map).
   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_ent
      logic [ADDR_W-1:0] base_q;
      logic [ADDR_W-1:0] mask_q;
      logic              en_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            base_q <= ADDR_W'(gi) << (ADDR_W - IDX_W);
            mask_q <= {{IDX_W{1'b1}}, {(ADDR_W - IDX_W){1'b0}}};
            en_q   <= 1'b1;
         end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
            case (cfg_sel)
               2'b00:   base_q <= cfg_wdata;
               2'b01:   mask_q <= cfg_wdata;
               2'b10:   en_q   <= cfg_wdata[0];
               default: ;
            endcase
         end
      end

      assign hit[gi] = en_q && ((bus.s_addr & mask_q) == (base_q & mask_q));
   end

   // Lowest matching index wins: scan downwards so the last hit kept is lowest.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign cnt_d = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cs_q       <= '1;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         err_rdy_q  <= 1'b1;
         err_code_q <= 2'b00;
         cnt_q      <= '0;
      end else begin
         // Error ready is a single-cycle pulse unless re-asserted below.
         err_rdy_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (!bus.s_as_) begin
                  busy_q <= 1'b1;
                  if (hit_any) begin
                     cs_q       <= ~(N_SLAVES'(1) << hit_idx);
                     idx_q      <= hit_idx;
                     err_code_q <= 2'b00;
                     cnt_q      <= '0;
                     state_q    <= ACTIVE;
                  end else begin
                     err_rdy_q  <= 1'b0;
                     err_code_q <= 2'b01;
                     state_q    <= ERR;
                  end
               end
            end
            ACTIVE: begin
               cnt_q <= cnt_d;
               // Ready has priority over a timeout landing on the same cycle.
               if (!bus.s_rdy_) begin
                  cs_q    <= '1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                  cs_q       <= '1;
                  err_rdy_q  <= 1'b0;
                  err_code_q <= 2'b10;
                  state_q    <= ERR;
               end
            end
            ERR: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s_cs_    = cs_q;
   assign bus.s_idx    = idx_q;
   assign bus.busy     = busy_q;
   assign bus.err_rdy_ = err_rdy_q;
   assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_bus_addr_dec_prog.sv
// -----------------------------------------------------------------------------
// tb_bus_addr_dec_prog
// Directed bench for bus_addr_dec_prog (8 slaves, 30-bit address, TIMEOUT=4).
// With default decoding the slave index is address bits [29:27].
// -----------------------------------------------------------------------------
module tb_bus_addr_dec_prog;
   localparam int ADDR_W   = 30;
   localparam int N_SLAVES = 8;
   localparam int IDX_W    = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [1:0]        cfg_sel;
   logic [ADDR_W-1:0] cfg_wdata;

   int checks   = 0;
   int failures = 0;

   bus_addr_dec_prog_if #(.ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES), .IDX_W(IDX_W)) bus ();

   bus_addr_dec_prog #(
      .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES), .IDX_W(IDX_W), .TIMEOUT(4), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata)
   );

   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] cs, input logic [2:0] idx,
                            input logic bsy, input logic erdy, input logic [1:0] ecode);
      chk({tag, ".cs"},       32'(bus.s_cs_),    32'(cs));
      chk({tag, ".idx"},      32'(bus.s_idx),    32'(idx));
      chk({tag, ".busy"},     32'(bus.busy),     32'(bsy));
      chk({tag, ".err_rdy"},  32'(bus.err_rdy_), 32'(erdy));
      chk({tag, ".err_code"}, 32'(bus.err_code), 32'(ecode));
      $display("step %-10s cs=%02h idx=%0d busy=%0b err_rdy_=%0b err_code=%02b",
               tag, bus.s_cs_, bus.s_idx, bus.busy, bus.err_rdy_, bus.err_code);
   endtask

   task automatic cfg_write(input logic [2:0] idx, input logic [1:0] sel, input logic [29:0] data);
      cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic strobe(input logic [29:0] addr);
      bus.s_addr = addr; bus.s_as_ = 1'b0;
      tick();
      bus.s_as_ = 1'b1;
   endtask

   task automatic ready();
      bus.s_rdy_ = 1'b0;
      tick();
      bus.s_rdy_ = 1'b1;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
      bus.s_addr = '0; bus.s_as_ = 1'b1; bus.s_rdy_ = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      check_out("reset", 8'hFF, 3'd0, 1'b0, 1'b1, 2'b00);

      // Default decode: 0x0800_0000 -> slave 1, ready two cycles after select.
      strobe(30'h0800_0000);
      check_out("sel1", 8'hFD, 3'd1, 1'b1, 1'b1, 2'b00);
      tick();
      check_out("sel1_hold", 8'hFD, 3'd1, 1'b1, 1'b1, 2'b00);
      ready();
      check_out("sel1_done", 8'hFF, 3'd1, 1'b0, 1'b1, 2'b00);

      // 0x2000_0000 has top bits 100 -> slave 4.
      strobe(30'h2000_0000);
      check_out("sel4", 8'hEF, 3'd4, 1'b1, 1'b1, 2'b00);
      ready();
      check_out("sel4_done", 8'hFF, 3'd4, 1'b0, 1'b1, 2'b00);

      // Disabled entry 3 -> decode miss, one-cycle error ready.
      cfg_write(3'd3, 2'b10, 30'h0);
      strobe(30'h1800_0000);
      check_out("miss", 8'hFF, 3'd4, 1'b1, 1'b0, 2'b01);
      tick();
      check_out("miss_end", 8'hFF, 3'd4, 1'b0, 1'b1, 2'b01);
      tick();
      check_out("miss_idle", 8'hFF, 3'd4, 1'b0, 1'b1, 2'b01);

      // Ignored writes: sel=11 must not disturb entry 3's enable.
      cfg_write(3'd3, 2'b10, 30'h1);
      cfg_write(3'd3, 2'b11, 30'h0);
      // Entry 0 overlaps entry 3's region; lowest index wins.
      cfg_write(3'd0, 2'b00, 30'h1800_0000);
      cfg_write(3'd0, 2'b01, 30'h3FFF_F000);
      strobe(30'h1800_0010);
      check_out("prio0", 8'hFE, 3'd0, 1'b1, 1'b1, 2'b00);
      ready();
      // Outside entry 0's window, entry 3 (re-enabled) answers.
      strobe(30'h1800_1000);
      check_out("sel3", 8'hF7, 3'd3, 1'b1, 1'b1, 2'b00);
      ready();
      check_out("sel3_done", 8'hFF, 3'd3, 1'b0, 1'b1, 2'b00);

      // Timeout: slave 2 never answers; select stays low exactly 4 cycles.
      strobe(30'h1000_0000);
      check_out("to_c1", 8'hFB, 3'd2, 1'b1, 1'b1, 2'b00);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check_out($sformatf("to_c%0d", i), 8'hFB, 3'd2, 1'b1, 1'b1, 2'b00);
      end
      tick();
      check_out("to_err", 8'hFF, 3'd2, 1'b1, 1'b0, 2'b10);
      tick();
      check_out("to_end", 8'hFF, 3'd2, 1'b0, 1'b1, 2'b10);

      // Ready on the timeout cycle wins.
      strobe(30'h1000_0000);
      check_out("rt_sel", 8'hFB, 3'd2, 1'b1, 1'b1, 2'b00);
      tick(); tick(); tick();
      check_out("rt_c4", 8'hFB, 3'd2, 1'b1, 1'b1, 2'b00);
      ready();
      check_out("rt_done", 8'hFF, 3'd2, 1'b0, 1'b1, 2'b00);

      // Rewriting entry 1 while it is active leaves the latched selection.
      strobe(30'h0800_0000);
      cfg_write(3'd1, 2'b00, 30'h2800_0000);
      check_out("live_cfg", 8'hFD, 3'd1, 1'b1, 1'b1, 2'b00);
      ready();
      check_out("live_done", 8'hFF, 3'd1, 1'b0, 1'b1, 2'b00);
      // Old address now misses; new base selects entry 1 ahead of entry 5.
      strobe(30'h0800_0000);
      check_out("old_miss", 8'hFF, 3'd1, 1'b1, 1'b0, 2'b01);
      tick();
      strobe(30'h2800_0000);
      check_out("new_base", 8'hFD, 3'd1, 1'b1, 1'b1, 2'b00);

      // Reset mid-transaction restores outputs and table.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_out("mid_rst", 8'hFF, 3'd0, 1'b0, 1'b1, 2'b00);
      strobe(30'h0800_0000);
      check_out("rst_sel1", 8'hFD, 3'd1, 1'b1, 1'b1, 2'b00);
      ready();
      strobe(30'h1800_0010);
      check_out("rst_sel3", 8'hF7, 3'd3, 1'b1, 1'b1, 2'b00);
      ready();
      // s_rdy_ outside ACTIVE has no effect.
      ready();
      check_out("rdy_idle", 8'hFF, 3'd3, 1'b0, 1'b1, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
